// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone arbiter.
// Holds the FSM state encoding, the outstanding-counter width, the Wishbone
// CTI/BTE cycle-type encodings and the bundled request struct used by the mux.
package wb_arb_pkg;

    localparam int OUTST_W = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_GRANT = 2'd1;
    localparam arb_state_t ST_DRAIN = 2'd2;

    localparam logic [2:0] CTI_CLASSIC     = 3'b000;
    localparam logic [2:0] CTI_CONST_BURST = 3'b001;
    localparam logic [2:0] CTI_INCR_BURST  = 3'b010;
    localparam logic [2:0] CTI_END_BURST   = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Request fields that travel together from the owning master to the slave.
    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [31:0] dat_wr;
    } wb_req_t;

endpackage

// File: rtl/wb_arb_mux.sv
// wb_arb_mux: request/response steering between two masters and one slave.
// Purely combinational; the FSM in wb_arb_2m tells it who owns the bus and
// whether the bus is in address-phase (grant) or wait-for-responses (drain).
module wb_arb_mux
    import wb_arb_pkg::*;
(
    input  logic        owner,
    input  logic        grant,
    input  logic        drain,
    input  logic        limit,
    input  logic [31:0] m0_adr,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [2:0]  m0_cti,
    input  logic [1:0]  m0_bte,
    input  logic [31:0] m0_dat_wr,
    input  logic [31:0] m1_adr,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [2:0]  m1_cti,
    input  logic [1:0]  m1_bte,
    input  logic [31:0] m1_dat_wr,
    input  logic        s_stall,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic [31:0] s_dat_rd,
    output logic [31:0] s_adr,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [2:0]  s_cti,
    output logic [1:0]  s_bte,
    output logic [31:0] s_dat_wr,
    output logic        m0_stall,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_dat_rd,
    output logic        m1_stall,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_dat_rd
);

    wb_req_t m0_req;
    wb_req_t m1_req;
    wb_req_t own_req;
    logic    own_stall;

    assign m0_req = {m0_adr, m0_we, m0_sel, m0_cti, m0_bte, m0_dat_wr};
    assign m1_req = {m1_adr, m1_we, m1_sel, m1_cti, m1_bte, m1_dat_wr};

    // Slave request: owner's fields while the bus is held; CYC/STB shaped by state.
    always_comb begin
        own_req  = owner ? m1_req : m0_req;
        s_adr    = '0;
        s_we     = 1'b0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        s_dat_wr = '0;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        if (grant || drain) begin
            s_adr    = own_req.adr;
            s_we     = own_req.we;
            s_sel    = own_req.sel;
            s_cti    = own_req.cti;
            s_bte    = own_req.bte;
            s_dat_wr = own_req.dat_wr;
        end
        if (grant) begin
            s_cyc = owner ? m1_cyc : m0_cyc;
            s_stb = (owner ? m1_stb : m0_stb) & ~limit;
        end else if (drain) begin
            s_cyc = 1'b1;
        end
    end

    // Master responses: only the owner sees the slave; everyone else is parked.
    always_comb begin
        own_stall = drain | s_stall | limit;
        m0_stall  = 1'b1;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m0_dat_rd = '0;
        m1_stall  = 1'b1;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m1_dat_rd = '0;
        if (grant || drain) begin
            if (owner) begin
                m1_stall  = own_stall;
                m1_ack    = s_ack;
                m1_err    = s_err;
                m1_dat_rd = s_dat_rd;
            end else begin
                m0_stall  = own_stall;
                m0_ack    = s_ack;
                m0_err    = s_err;
                m0_dat_rd = s_dat_rd;
            end
        end
    end

endmodule

// File: rtl/wb_arb_2m.sv
// wb_arb_2m: two-master to one-slave pipelined Wishbone arbiter.
// Optional feature: define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise M0 has fixed priority when both masters request.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner on the bus; pick one when any CYC is high
// ST_GRANT | owner drives the slave; address phases throttled by OUTST_MAX
// ST_DRAIN | owner dropped CYC with phases in flight; wait for ACK/ERR
module wb_arb_2m
    import wb_arb_pkg::*;
#(
    parameter int OUTST_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST_SYNC,
    input  logic [31:0] M0_WB_ADR_IN,
    input  logic        M0_WB_CYC_IN,
    input  logic        M0_WB_STB_IN,
    input  logic        M0_WB_WE_IN,
    input  logic [3:0]  M0_WB_SEL_IN,
    input  logic [2:0]  M0_WB_CTI_IN,
    input  logic [1:0]  M0_WB_BTE_IN,
    input  logic [31:0] M0_WB_DAT_WR_IN,
    output logic        M0_WB_STALL_OUT,
    output logic        M0_WB_ACK_OUT,
    output logic        M0_WB_ERR_OUT,
    output logic [31:0] M0_WB_DAT_RD_OUT,
    input  logic [31:0] M1_WB_ADR_IN,
    input  logic        M1_WB_CYC_IN,
    input  logic        M1_WB_STB_IN,
    input  logic        M1_WB_WE_IN,
    input  logic [3:0]  M1_WB_SEL_IN,
    input  logic [2:0]  M1_WB_CTI_IN,
    input  logic [1:0]  M1_WB_BTE_IN,
    input  logic [31:0] M1_WB_DAT_WR_IN,
    output logic        M1_WB_STALL_OUT,
    output logic        M1_WB_ACK_OUT,
    output logic        M1_WB_ERR_OUT,
    output logic [31:0] M1_WB_DAT_RD_OUT,
    output logic [31:0] S_WB_ADR_OUT,
    output logic        S_WB_CYC_OUT,
    output logic        S_WB_STB_OUT,
    output logic        S_WB_WE_OUT,
    output logic [3:0]  S_WB_SEL_OUT,
    output logic [2:0]  S_WB_CTI_OUT,
    output logic [1:0]  S_WB_BTE_OUT,
    output logic [31:0] S_WB_DAT_WR_OUT,
    input  logic        S_WB_STALL_IN,
    input  logic        S_WB_ACK_IN,
    input  logic        S_WB_ERR_IN,
    input  logic [31:0] S_WB_DAT_RD_IN
);

    localparam logic [OUTST_W-1:0] LIMIT_VAL = OUTST_W'(OUTST_MAX);

    arb_state_t         state;
    logic               owner;
    logic               next_owner;
    logic [OUTST_W-1:0] outst;
    logic [OUTST_W-1:0] outst_nxt;
    logic               grant;
    logic               drain;
    logic               limit;
    logic               accept;
    logic               resp;
    logic               own_cyc;

    assign grant   = (state == ST_GRANT);
    assign drain   = (state == ST_DRAIN);
    assign limit   = (outst == LIMIT_VAL);
    assign own_cyc = owner ? M1_WB_CYC_IN : M0_WB_CYC_IN;
    assign accept  = S_WB_CYC_OUT & S_WB_STB_OUT & ~S_WB_STALL_IN;
    // A response with nothing in flight is stray and must not underflow.
    assign resp    = (S_WB_ACK_IN | S_WB_ERR_IN) & (outst != '0);

    // Outstanding count after this cycle's accepted phase and/or response.
    always_comb begin
        outst_nxt = outst;
        if (accept && !resp) begin
            outst_nxt = outst + 1'b1;
        end else if (!accept && resp) begin
            outst_nxt = outst - 1'b1;
        end
    end

    // Arbitration decision taken in IDLE; a lone requester always wins.
    always_comb begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (M0_WB_CYC_IN && M1_WB_CYC_IN) begin
            next_owner = ~owner;
        end else begin
            next_owner = M1_WB_CYC_IN;
        end
`else
        next_owner = ~M0_WB_CYC_IN;
`endif
    end

    // FSM, owner register and outstanding counter.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            state <= ST_IDLE;
            owner <= 1'b1;
            outst <= '0;
        end else begin
            outst <= outst_nxt;
            case (state)
                ST_IDLE: begin
                    if (M0_WB_CYC_IN || M1_WB_CYC_IN) begin
                        owner <= next_owner;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!own_cyc) begin
                        state <= (outst_nxt == '0) ? ST_IDLE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outst_nxt == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_arb_mux u_mux (
        .owner     (owner),
        .grant     (grant),
        .drain     (drain),
        .limit     (limit),
        .m0_adr    (M0_WB_ADR_IN),
        .m0_cyc    (M0_WB_CYC_IN),
        .m0_stb    (M0_WB_STB_IN),
        .m0_we     (M0_WB_WE_IN),
        .m0_sel    (M0_WB_SEL_IN),
        .m0_cti    (M0_WB_CTI_IN),
        .m0_bte    (M0_WB_BTE_IN),
        .m0_dat_wr (M0_WB_DAT_WR_IN),
        .m1_adr    (M1_WB_ADR_IN),
        .m1_cyc    (M1_WB_CYC_IN),
        .m1_stb    (M1_WB_STB_IN),
        .m1_we     (M1_WB_WE_IN),
        .m1_sel    (M1_WB_SEL_IN),
        .m1_cti    (M1_WB_CTI_IN),
        .m1_bte    (M1_WB_BTE_IN),
        .m1_dat_wr (M1_WB_DAT_WR_IN),
        .s_stall   (S_WB_STALL_IN),
        .s_ack     (S_WB_ACK_IN),
        .s_err     (S_WB_ERR_IN),
        .s_dat_rd  (S_WB_DAT_RD_IN),
        .s_adr     (S_WB_ADR_OUT),
        .s_cyc     (S_WB_CYC_OUT),
        .s_stb     (S_WB_STB_OUT),
        .s_we      (S_WB_WE_OUT),
        .s_sel     (S_WB_SEL_OUT),
        .s_cti     (S_WB_CTI_OUT),
        .s_bte     (S_WB_BTE_OUT),
        .s_dat_wr  (S_WB_DAT_WR_OUT),
        .m0_stall  (M0_WB_STALL_OUT),
        .m0_ack    (M0_WB_ACK_OUT),
        .m0_err    (M0_WB_ERR_OUT),
        .m0_dat_rd (M0_WB_DAT_RD_OUT),
        .m1_stall  (M1_WB_STALL_OUT),
        .m1_ack    (M1_WB_ACK_OUT),
        .m1_err    (M1_WB_ERR_OUT),
        .m1_dat_rd (M1_WB_DAT_RD_OUT)
    );

endmodule
